// File: rtl/vec_issue_ctrl_pkg.sv
// rtl/vec_issue_ctrl_pkg.sv - shared vector control definitions
package vec_issue_ctrl_pkg;

    typedef enum logic [6:0] {
        OPC_V = 7'h57
    } v_opcode_e;

    typedef enum logic [2:0] {
        F3_OPIVV = 3'b000,
        F3_OPFVV = 3'b001,
        F3_OPMVV = 3'b010,
        F3_OPIVI = 3'b011,
        F3_OPIVX = 3'b100,
        F3_OPFVF = 3'b101,
        F3_OPMVX = 3'b110,
        F3_OPCFG = 3'b111
    } v_func3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG,
        S_ISSUE
    } ctrl_state_e;

    localparam int VLMUL_LSB      = 0;
    localparam int VLMUL_MSB      = 2;
    localparam int VSEW_LSB       = 3;
    localparam int VSEW_MSB       = 5;
    localparam int VTYPE_RSVD_LSB = 6;

    localparam logic [2:0] VSEW_MAX  = 3'd2;
    localparam logic [2:0] VLMUL_MAX = 3'd3;

    function automatic int vill_bit(input int xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/vec_issue_ctrl_vl_calc.sv
// rtl/vec_issue_ctrl_vl_calc.sv - vtype legality, VLMAX, AVL select and vl clamp
module vec_vl_calc #(
    parameter int XLEN = 32,
    parameter int VLEN = 512
) (
    input  logic [XLEN-1:0] i_vtype,
    input  logic            i_is_imm,
    input  logic [4:0]      i_rs1_field,
    input  logic [4:0]      i_rd_field,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_cur_vl,
    output logic            o_legal,
    output logic [XLEN-1:0] o_vl,
    output logic [XLEN-1:0] o_vtype
);
    import vec_issue_ctrl_pkg::*;

    localparam logic [XLEN-1:0] VLEN_X     = XLEN'(VLEN);
    localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      w_vlmul;
    logic [2:0]      w_vsew;
    logic [3:0]      w_shr;
    logic [XLEN-1:0] w_vlmax;
    logic [XLEN-1:0] w_avl;
    logic [XLEN-1:0] w_clamped;

    assign w_vlmul = i_vtype[VLMUL_MSB:VLMUL_LSB];
    assign w_vsew  = i_vtype[VSEW_MSB:VSEW_LSB];

    // A requested vill bit is treated like any other reserved bit.
    assign o_legal = (w_vsew <= VSEW_MAX) && (w_vlmul <= VLMUL_MAX) &&
                     (i_vtype[XLEN-1:VTYPE_RSVD_LSB] == '0);

    assign w_shr   = {1'b0, w_vsew} + 4'd3;
    assign w_vlmax = (VLEN_X << w_vlmul) >> w_shr;

    always_comb begin
        w_avl = i_cur_vl;
        if (i_is_imm) begin
            w_avl = {{(XLEN-5){1'b0}}, i_rs1_field};
        end else if (i_rs1_field != 5'd0) begin
            w_avl = i_rs1_val;
        end else if (i_rd_field != 5'd0) begin
            w_avl = w_vlmax;
        end
    end

    assign w_clamped = (w_avl < w_vlmax) ? w_avl : w_vlmax;
    assign o_vl      = o_legal ? w_clamped : '0;
    assign o_vtype   = o_legal ? i_vtype : VILL_VTYPE;

endmodule

// File: rtl/vec_issue_ctrl.sv
// rtl/vec_issue_ctrl.sv - single-issue vector controller owning vl/vtype
module vec_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int VLEN  = 512,
    parameter int LANES = 4,
    parameter int IDXW  = $clog2(VLEN) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inst_valid,
    output logic                    inst_ready,
    input  logic [XLEN-1:0]         vec_inst,
    input  logic [XLEN-1:0]         rs1_i,
    input  logic [XLEN-1:0]         rs2_i,
    output logic [XLEN-1:0]         csr_vl,
    output logic [XLEN-1:0]         csr_vtype,
    output logic                    rd_wr_en,
    output logic [4:0]              rd_addr,
    output logic [XLEN-1:0]         rd_data,
    output logic                    uop_valid,
    input  logic                    uop_ready,
    output logic [XLEN-1:0]         uop_inst,
    output logic [IDXW-1:0]         uop_elem_idx,
    output logic [$clog2(LANES):0]  uop_elem_cnt,
    output logic                    uop_last,
    output logic                    done,
    output logic                    illegal
);
    import vec_issue_ctrl_pkg::*;

    localparam int              CNTW       = $clog2(LANES) + 1;
    localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

    ctrl_state_e     r_state;
    ctrl_state_e     w_state_nxt;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_csr_vl;
    logic [XLEN-1:0] r_csr_vtype;
    logic [IDXW-1:0] r_elem_idx;
    logic            r_done_pend;
    logic            r_illegal;

    logic            w_accept;
    logic            w_in_is_v;
    logic            w_in_is_cfg;
    logic            w_issue_skip;
    logic [XLEN-1:0] w_cfg_vtype;
    logic            w_cfg_is_imm;
    logic            w_cfg_legal;
    logic [XLEN-1:0] w_cfg_vl;
    logic [XLEN-1:0] w_cfg_vtype_out;
    logic [XLEN-1:0] w_idx_x;
    logic [XLEN-1:0] w_remain;
    logic [CNTW-1:0] w_cnt;
    logic            w_last;
    logic [4:0]      w_rd;

    assign w_accept     = inst_valid && (r_state == S_IDLE);
    assign w_in_is_v    = (vec_inst[6:0] == OPC_V);
    assign w_in_is_cfg  = w_in_is_v && (vec_inst[14:12] == F3_OPCFG);
    assign w_issue_skip = (r_csr_vl == '0) || r_csr_vtype[vill_bit(XLEN)];
    assign w_rd         = r_inst[11:7];

    // vsetvli carries an 11-bit zimm, vsetivli a 10-bit one, vsetvl uses rs2.
    assign w_cfg_is_imm = r_inst[31] && r_inst[30];
    always_comb begin
        w_cfg_vtype = r_rs2;
        if (!r_inst[31]) begin
            w_cfg_vtype = {{(XLEN-11){1'b0}}, r_inst[30:20]};
        end else if (r_inst[30]) begin
            w_cfg_vtype = {{(XLEN-10){1'b0}}, r_inst[29:20]};
        end
    end

    vec_vl_calc #(
        .XLEN (XLEN),
        .VLEN (VLEN)
    ) u_vl_calc (
        .i_vtype     (w_cfg_vtype),
        .i_is_imm    (w_cfg_is_imm),
        .i_rs1_field (r_inst[19:15]),
        .i_rd_field  (w_rd),
        .i_rs1_val   (r_rs1),
        .i_cur_vl    (r_csr_vl),
        .o_legal     (w_cfg_legal),
        .o_vl        (w_cfg_vl),
        .o_vtype     (w_cfg_vtype_out)
    );

    assign w_idx_x  = XLEN'(r_elem_idx);
    assign w_remain = r_csr_vl - w_idx_x;
    assign w_cnt    = (w_remain >= XLEN'(LANES)) ? CNTW'(LANES) : w_remain[CNTW-1:0];
    assign w_last   = (w_idx_x + XLEN'(LANES)) >= r_csr_vl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        inst_ready   = 1'b0;
        rd_wr_en     = 1'b0;
        rd_data      = '0;
        uop_valid    = 1'b0;
        uop_elem_cnt = '0;
        uop_last     = 1'b0;
        done         = r_done_pend;
        case (r_state)
            S_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid && w_in_is_cfg) begin
                    w_state_nxt = S_CFG;
                end else if (inst_valid && w_in_is_v && !w_issue_skip) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_CFG: begin
                rd_wr_en    = (w_rd != 5'd0);
                rd_data     = w_cfg_vl;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ISSUE: begin
                uop_valid    = 1'b1;
                uop_elem_cnt = w_cnt;
                uop_last     = w_last;
                if (uop_ready && w_last) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst      <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_csr_vl    <= '0;
            r_csr_vtype <= VILL_VTYPE;
            r_elem_idx  <= '0;
            r_done_pend <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_done_pend <= 1'b0;
            r_illegal   <= 1'b0;
            if (w_accept) begin
                r_inst     <= vec_inst;
                r_rs1      <= rs1_i;
                r_rs2      <= rs2_i;
                r_elem_idx <= '0;
                if (!w_in_is_v) begin
                    r_illegal <= 1'b1;
                end else if (!w_in_is_cfg && w_issue_skip) begin
                    r_done_pend <= 1'b1;
                end
            end
            if (r_state == S_CFG) begin
                r_csr_vl    <= w_cfg_vl;
                r_csr_vtype <= w_cfg_vtype_out;
            end
            if ((r_state == S_ISSUE) && uop_ready && !w_last) begin
                r_elem_idx <= r_elem_idx + IDXW'(LANES);
            end
        end
    end

    assign csr_vl       = r_csr_vl;
    assign csr_vtype    = r_csr_vtype;
    assign rd_addr      = w_rd;
    assign uop_inst     = r_inst;
    assign uop_elem_idx = r_elem_idx;
    assign illegal      = r_illegal;

endmodule

// File: doc/vec_issue_ctrl.md
Name: vec_issue_ctrl

Overview:
- Single-issue controller between the scalar core and the vector datapath.
- Accepts one vector instruction at a time over a valid/ready handshake and owns the vl/vtype CSRs.
- Executes vsetvli/vsetivli/vsetvl, including the write-back of the new vl to scalar rd.
- Sequences arithmetic instructions as element-group micro-ops, LANES elements per group, until vl elements are covered.

Parameters:
- XLEN, 32, scalar/CSR width
- VLEN, 512, vector register length in bits
- LANES, 4, elements issued per micro-op
- IDXW, $clog2(VLEN)+1, element index width

Ports:
- clk in 1: clock
- reset in 1: asynchronous, active-high reset
- inst_valid in 1: instruction offered
- inst_ready out 1: controller can accept
- vec_inst in XLEN: instruction word
- rs1_i in XLEN: scalar rs1 value, sampled on accept
- rs2_i in XLEN: scalar rs2 value, sampled on accept
- csr_vl out XLEN: current vl
- csr_vtype out XLEN: current vtype
- rd_wr_en out 1: scalar write-back strobe
- rd_addr out 5: write-back register
- rd_data out XLEN: write-back data (new vl)
- uop_valid out 1: micro-op valid
- uop_ready in 1: datapath accepts micro-op
- uop_inst out XLEN: latched instruction
- uop_elem_idx out IDXW: first element of group
- uop_elem_cnt out $clog2(LANES)+1: active elements in group
- uop_last out 1: final group
- done out 1: one-cycle completion pulse
- illegal out 1: one-cycle pulse, non-vector opcode dropped

Behaviour:
- Clock/reset interface: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, csr_vl=0, csr_vtype=1<<(XLEN-1) (vill). rd_wr_en, uop_valid, done, illegal, uop_elem_idx and all latched fields are 0. inst_ready=1 once reset deasserts.
- Reset mid-operation aborts everything; no partial CSR update survives.
- Field decode: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], uimm=[19:15].
- vtype fields: vlmul=[2:0], vsew=[5:3], vill=[XLEN-1].
- inst_ready=(state==IDLE), combinational. Fields are latched on inst_valid&&inst_ready.
- IDLE accept routing:
  - opcode 0x57, funct3=111 -> CFG.
  - opcode 0x57, other funct3:
    - if csr_vl==0 or vill: pulse done next cycle, stay IDLE, no uop.
    - else -> ISSUE with elem_idx=0.
  - any other opcode: pulse illegal next cycle, stay IDLE.
- CFG (exactly 1 cycle):
  - New vtype source:
    - vsetvli (bit31=0): zimm=[30:20].
    - vsetivli (bits31:30=11): zimm=[29:20].
    - vsetvl (bits31:30=10): rs2 value.
  - Legal iff vsew<=2, vlmul<=3, and all other bits below vill are 0.
  - VLMAX=(VLEN<<vlmul)>>(3+vsew).
  - AVL selection:
    - vsetivli: AVL=uimm.
    - Otherwise, rs1!=x0: AVL=rs1 value.
    - rs1==x0, rd!=x0: AVL=VLMAX.
    - rs1==x0, rd==x0: AVL=current csr_vl.
  - new vl=min(AVL,VLMAX).
  - Illegal vtype: vtype=1<<(XLEN-1), vl=0.
  - During CFG: rd_wr_en=(rd!=0), rd_addr=rd, rd_data=new vl, done=1.
  - CSRs update at the end of CFG, then -> IDLE.
- ISSUE:
  - uop_valid=1, uop_inst=latched instruction.
  - uop_elem_cnt=min(LANES, csr_vl-elem_idx).
  - uop_last=(elem_idx+LANES>=csr_vl).
  - On uop_ready, not last: elem_idx+=LANES.
  - On uop_ready and last: done=1 that cycle, -> IDLE.
  - All uop outputs remain stable while uop_valid&&!uop_ready.
- Latency: config = 1 cycle after accept. Arithmetic = ceil(vl/LANES) handshakes minimum.
- CSRs cannot change during ISSUE (single-issue), so csr_vl is the snapshot.

Decomposition:
- Shared vec defs package:
  - v_opcode_e / v_func3_e (existing)
  - ctrl state enum {IDLE, CFG, ISSUE}
  - VILL_BIT, vtype field positions, vsew/vlmul legal limits
- Sub-module vec_vl_calc (combinational): vtype legality, VLMAX, AVL select, min clamp. It is reused by any future CSR-write path.

Test Plan:
- Reset -> csr_vl=0, csr_vtype=0x8000_0000, inst_ready=1, uop_valid=0.
- vsetvli x5,x6,e32,m1 (zimm=0x010), rs1_i=10 -> one cycle rd_wr_en=1, rd_addr=5, rd_data=10; then csr_vl=10, csr_vtype=0x10. Repeat with rs1_i=100 -> vl=16.
- vsetivli x0,7,e8,m8 -> vtype=0x03, vl=7, rd_wr_en=0. vsetvli x3,x0,e8,m8 -> vl=512, rd_data=512.
- vl=10, vadd.vv -> three uops, idx 0/4/8, cnt 4/4/2, uop_last on third, done with the third handshake. Hold uop_ready=0 for 2 cycles on the second uop -> outputs unchanged.
- vsetvl rs2_i=0x20 (vsew=4) -> csr_vtype=0x8000_0000, vl=0. Following vadd -> done next cycle, uop_valid never asserted.
- Opcode 0x33 offered -> accepted, illegal pulse, CSRs unchanged. Reset asserted mid-ISSUE -> uop_valid drops asynchronously, csr_vl=0.
